cs_check: RTL
=============

Name: cs_check

Overview:
- Receive-side checker for the CheckSum protocol. CS produces one 8-bit one's-complement checksum per data segment: segment 1 is 384 bits and segment 2 is 128 bits.
- cs_check takes a byte stream containing segment 1, its checksum byte, segment 2, and its checksum byte.
- It recomputes both checksums and reports per-segment pass/fail plus the computed values.
- It sits downstream of the link that carries CS output, in the same bench and system.

Parameters:
- WIDTH_DATA_1, 384, segment 1 payload bits; multiple of 8.
- WIDTH_RESULT_1, 8, segment 1 checksum width; fixed at 8.
- WIDTH_DATA_2, 128, segment 2 payload bits; multiple of 8.
- WIDTH_RESULT_2, 8, segment 2 checksum width; fixed at 8.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data byte valid this cycle.
- data  in  8  stream byte; MSB-first byte order within each segment.
- out_valid  out  1  one-cycle result strobe.
- result  out  16  {computed cs1, computed cs2}.
- pass  out  2  {pass1, pass2}; bit 1 = segment 1.
- err  out  1  abort flag; driven only when CS_CHK_TIMEOUT_EN is defined, otherwise tied 0.

Behaviour:
- Reset: all outputs are 0, state = IDLE, counters and sums are 0. Reset mid-packet discards the packet and produces no out_valid.
- N1 = WIDTH_DATA_1/8 (48) and N2 = WIDTH_DATA_2/8 (16).
- A packet is N1 + 1 + N2 + 1 accepted bytes (66 by default).
- Bytes are accepted only on cycles with in_valid = 1. Gaps of in_valid = 0 stall the FSM with no state change.
- FSM states and transitions:
  - IDLE: on an accepted byte, go to SEG1 and count it as byte 0.
  - SEG1: go to CHK1 after byte N1-1.
  - CHK1: one accepted byte, then go to SEG2.
  - SEG2: go to CHK2 after byte N2-1.
  - CHK2: one accepted byte, then go to IDLE and fire the output.
- Arithmetic: 8-bit one's-complement add, s' = (s + b)[7:0] + carry (end-around carry).
  - sum_d accumulates data bytes only.
  - sum_t = sum_d one's-complement-added with the received checksum byte.
  - Computed cs = ~sum_d.
  - pass = (sum_t == 8'hFF). A received 0x00 or 0xFF therefore both pass when the computed cs is 0x00 (+0/−0).
  - Sums restart at 0 at the first byte of each segment.
- Latency: out_valid = 1 exactly one cycle after the CHK2 byte is accepted. result and pass are valid in that same cycle and hold until the next out_valid (or the next err strobe, or reset).
- Back-to-back packets: a new packet's byte 0 may arrive in the cycle after CHK2. It is accepted normally, concurrently with the out_valid pulse.
- Byte counter is 6 bits. It never wraps within a segment and is cleared at each segment transition.

Optional Feature:
- Macro: CS_CHK_TIMEOUT_EN.
- Defined:
  - An idle counter runs while state != IDLE and in_valid = 0, and clears on any accepted byte.
  - When it reaches 16 consecutive idle cycles, the block returns to IDLE and pulses out_valid = 1 with err = 1 and pass = 2'b00 for one cycle. result holds its previous value.
  - Reset clears the counter.
- Not defined: stalls are unbounded and err is constant 0.

Decomposition:
- Shared package cs_pkg:
  - FSM state enum {IDLE, SEG1, CHK1, SEG2, CHK2}.
  - Localparams N1, N2, and TIMEOUT_CYC = 16.
  - Function oc_add8(a, b) for the end-around-carry add, reused by CS.
- Sub-module cs_oc_acc: 8-bit one's-complement accumulator with clear and enable. Two instances, one per sum_d/sum_t pair (or one time-shared instance).

Test Plan:
- Segment 1 bytes 0x01..0x30 with rx cs1 0x63; segment 2 all 0x00 with rx cs2 0xFF -> out_valid one cycle after the last byte, result = 16'h63FF, pass = 2'b11.
- Segment 2 all 0xFF (computed cs 0x00), sent twice with rx cs2 0x00 and then 0xFF -> pass[0] = 1 both times (+0/−0).
- Same as the first scenario but rx cs1 = 0x64 -> pass = 2'b01, result = 16'h63FF.
- Random in_valid gaps of 1–10 cycles, plus two packets back-to-back with no gap -> identical results to the gapless run, two distinct out_valid pulses, second packet's byte 0 not lost.
- rst asserted at byte 30 of segment 1, then a full valid packet -> no out_valid for the aborted packet, correct result for the new one.
- CS_CHK_TIMEOUT_EN defined, in_valid held low for 16 cycles after byte 10 -> one-cycle out_valid with err = 1, pass = 2'b00, then IDLE; a 15-cycle gap causes no abort.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared types and helpers for the CheckSum checker: FSM states, segment sizes,
// and the 8-bit one's-complement (end-around carry) add.
package cs_pkg;

  typedef enum logic [2:0] {IDLE, SEG1, CHK1, SEG2, CHK2} cs_state_t;

  localparam int N1          = 48;
  localparam int N2          = 16;
  localparam int TIMEOUT_CYC = 16;

  // A carry out of bit 7 can only occur when the low byte is <= 0xFE,
  // so folding it back in never overflows.
  function automatic logic [7:0] oc_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

endpackage

// File: rtl/cs_oc_acc.sv
// 8-bit one's-complement accumulator. Holds sum_d (data bytes only) and exposes
// sum_t = sum_d + current byte for checking the received checksum.
module cs_oc_acc
  import cs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_first,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum_d,
  output logic [7:0] o_sum_t
);

  logic [7:0] r_sum;

  // The first byte of a segment restarts the sum from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= 8'h00;
    end else if (i_en) begin
      r_sum <= oc_add8(i_first ? 8'h00 : r_sum, i_byte);
    end
  end

  assign o_sum_d = r_sum;
  assign o_sum_t = oc_add8(r_sum, i_byte);

endmodule

// File: rtl/cs_check.sv
// Receive-side CheckSum checker: recomputes both segment checksums and reports
// pass/fail. Optional stall timeout with err strobe under `CS_CHK_TIMEOUT_EN.
module cs_check
  import cs_pkg::*;
#(
  parameter int WIDTH_DATA_1   = N1 * 8,
  parameter int WIDTH_RESULT_1 = 8,
  parameter int WIDTH_DATA_2   = N2 * 8,
  parameter int WIDTH_RESULT_2 = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [7:0]                               data,
  output logic                                     out_valid,
  output logic [WIDTH_RESULT_1+WIDTH_RESULT_2-1:0] result,
  output logic [1:0]                               pass,
  output logic                                     err
);

  localparam int         SEG1_N = WIDTH_DATA_1 / 8;
  localparam int         SEG2_N = WIDTH_DATA_2 / 8;
  localparam logic [5:0] LAST1  = 6'(SEG1_N - 1);
  localparam logic [5:0] LAST2  = 6'(SEG2_N - 1);

  cs_state_t r_state, w_state_next;
  logic [5:0] r_cnt, w_cnt_next;
  logic       w_acc1_en, w_acc1_first, w_acc2_en, w_acc2_first;
  logic       w_chk1, w_fire;
  logic [7:0] w_sum_d1, w_sum_t1, w_sum_d2, w_sum_t2;
  logic       r_out_valid, r_pass1;
  logic [1:0] r_pass;
  logic [15:0] r_result;

  cs_oc_acc u_acc1 (
    .clk(clk), .rst(rst), .i_en(w_acc1_en), .i_first(w_acc1_first),
    .i_byte(data), .o_sum_d(w_sum_d1), .o_sum_t(w_sum_t1)
  );

  cs_oc_acc u_acc2 (
    .clk(clk), .rst(rst), .i_en(w_acc2_en), .i_first(w_acc2_first),
    .i_byte(data), .o_sum_d(w_sum_d2), .o_sum_t(w_sum_t2)
  );

`ifdef CS_CHK_TIMEOUT_EN
  logic [4:0] r_idle;
  logic       w_timeout;
  logic       r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc1_en    = 1'b0;
    w_acc1_first = 1'b0;
    w_acc2_en    = 1'b0;
    w_acc2_first = 1'b0;
    w_chk1       = 1'b0;
    w_fire       = 1'b0;
`ifdef CS_CHK_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      // r_cnt is zero in IDLE, so IDLE and SEG1 share the byte-index logic.
      IDLE, SEG1: if (in_valid) begin
        w_acc1_en    = 1'b1;
        w_acc1_first = (r_cnt == 6'd0);
        if (r_cnt == LAST1) begin
          w_state_next = CHK1;
          w_cnt_next   = 6'd0;
        end else begin
          w_state_next = SEG1;
          w_cnt_next   = r_cnt + 6'd1;
        end
      end
      CHK1: if (in_valid) begin
        w_chk1       = 1'b1;
        w_state_next = SEG2;
      end
      SEG2: if (in_valid) begin
        w_acc2_en    = 1'b1;
        w_acc2_first = (r_cnt == 6'd0);
        if (r_cnt == LAST2) begin
          w_state_next = CHK2;
          w_cnt_next   = 6'd0;
        end else begin
          w_cnt_next   = r_cnt + 6'd1;
        end
      end
      CHK2: if (in_valid) begin
        w_fire       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
`ifdef CS_CHK_TIMEOUT_EN
    if (r_state != IDLE && !in_valid && r_idle == 5'(TIMEOUT_CYC - 1)) begin
      w_timeout    = 1'b1;
      w_state_next = IDLE;
      w_cnt_next   = 6'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_pass1     <= 1'b0;
      r_pass      <= 2'b00;
      r_result    <= 16'h0000;
    end else begin
      r_out_valid <= w_fire;
      if (w_chk1) r_pass1 <= (w_sum_t1 == 8'hFF);
      // Segment 1 sum is untouched between its checksum byte and CHK2.
      if (w_fire) begin
        r_result <= {~w_sum_d1, ~w_sum_d2};
        r_pass   <= {r_pass1, (w_sum_t2 == 8'hFF)};
      end
`ifdef CS_CHK_TIMEOUT_EN
      if (w_timeout) begin
        r_out_valid <= 1'b1;
        r_pass      <= 2'b00;
      end
`endif
    end
  end

`ifdef CS_CHK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= 5'd0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= w_timeout;
      r_idle <= (in_valid || r_state == IDLE || w_timeout) ? 5'd0 : r_idle + 5'd1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign pass      = r_pass;

endmodule
